f_pc_npc: RTL

- Fetch-side stage of the 5-stage MIPS pipeline, directly upstream of the D-stage comparator: holds the F-stage PC, the F/D pipeline register, and the next-PC selection.
- Consumes the comparator's `jump` result and D-stage decode controls; produces `pc_F` for instruction memory and `instr_D` / `pc_D` / `pc8_D` for the D stage.
- Architectural branch delay slot: a control transfer resolved in D redirects the fetch after the one already in F.

---
 rtl/f_pc_npc.sv | 110 +++++++++++
 1 files changed

// File: rtl/f_pc_npc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | f_pc_npc : F-stage PC, F/D pipeline register and next-PC selection   |
// | Optional macro F_FETCH_EXC_EN adds fetch address-error detection.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module f_pc_npc #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instr_F,
  input  logic        jump,
  input  logic [2:0]  npc_op,
  input  logic [15:0] imm16_D,
  input  logic [25:0] imm26_D,
  input  logic [31:0] rs_D,
  output logic [31:0] pc_F,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D,
  output logic        valid_D
`ifdef F_FETCH_EXC_EN
  ,
  output logic        exc_adel_D
`endif
);

  localparam logic [2:0] c_op_seq     = 3'd0;
  localparam logic [2:0] c_op_br      = 3'd1;
  localparam logic [2:0] c_op_j       = 3'd2;
  localparam logic [2:0] c_op_jr      = 3'd3;
  localparam logic [2:0] c_op_jr_cond = 3'd4;

  logic [31:0] r_pc_F;
  logic [31:0] r_instr_D;
  logic [31:0] r_pc_D;
  logic        r_valid_D;

  logic [31:0] w_pc4;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_npc;
  logic [31:0] w_instr_in;

  assign w_pc4       = r_pc_F + 32'd4;
  assign w_br_target = r_pc_D + 32'd4 + {{14{imm16_D[15]}}, imm16_D, 2'b00};
  assign w_j_target  = {r_pc_D[31:28], imm26_D, 2'b00};

  // A bubble in D carries no transfer, so it always falls back to sequential fetch.
  always_comb begin
    w_npc = w_pc4;
    if (r_valid_D) begin
      case (npc_op)
        c_op_seq:     w_npc = w_pc4;
        c_op_br:      w_npc = jump ? w_br_target : w_pc4;
        c_op_j:       w_npc = w_j_target;
        c_op_jr:      w_npc = rs_D;
        c_op_jr_cond: w_npc = jump ? rs_D : w_pc4;
        default:      w_npc = w_pc4;
      endcase
    end
  end

`ifdef F_FETCH_EXC_EN
  logic w_fetch_fault;
  logic r_exc_adel_D;

  assign w_fetch_fault = (r_pc_F[1:0] != 2'b00) || (r_pc_F < IM_LO) || (r_pc_F > IM_HI);
  assign w_instr_in    = w_fetch_fault ? 32'd0 : instr_F;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exc_adel_D <= 1'b0;
    end else if (!stall) begin
      r_exc_adel_D <= w_fetch_fault;
    end
  end

  assign exc_adel_D = r_exc_adel_D;
`else
  assign w_instr_in = instr_F;
`endif

  // Stall freezes PC and F/D together; any redirect seen while stalled is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_F    <= PC_RESET;
      r_instr_D <= 32'd0;
      r_pc_D    <= 32'd0;
      r_valid_D <= 1'b0;
    end else if (!stall) begin
      r_pc_F    <= w_npc;
      r_instr_D <= w_instr_in;
      r_pc_D    <= r_pc_F;
      r_valid_D <= 1'b1;
    end
  end

  assign pc_F    = r_pc_F;
  assign instr_D = r_instr_D;
  assign pc_D    = r_pc_D;
  assign pc8_D   = r_pc_D + 32'd8;
  assign valid_D = r_valid_D;

endmodule
`default_nettype wire
